// File: rtl/br_pkg.sv
// br_pkg: shared widths, depth and types for the br_reg_bank register file.
package br_pkg;
    localparam int BR_DATA_W = 32;
    localparam int BR_ADDR_W = 5;
    localparam int NREGS = 2 ** BR_ADDR_W;
    typedef logic [BR_ADDR_W-1:0] br_addr_t;
    typedef logic [BR_DATA_W-1:0] br_data_t;
    localparam br_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/br_read_port.sv
// br_read_port: one combinational read port with x0 zeroing and, under BR_BYPASS_EN,
// same-cycle write-through forwarding from the write port.
module br_read_port
    import br_pkg::*;
#(
    parameter int DATA_W = BR_DATA_W
) (
    input  br_addr_t          addr_i,
    input  logic [DATA_W-1:0] regs_i [NREGS],
    input  logic              rst_n_i,
    input  logic              we_i,
    input  br_addr_t          a3_i,
    input  logic [DATA_W-1:0] wd3_i,
    output logic [DATA_W-1:0] rd_o
);
    logic [DATA_W-1:0] arr_rd;

    assign arr_rd = (addr_i == ZERO_REG) ? '0 : regs_i[addr_i];

`ifdef BR_BYPASS_EN
    // Forward only a write the bank would actually commit at the next edge.
    assign rd_o = (rst_n_i && we_i && a3_i != ZERO_REG && addr_i == a3_i) ? wd3_i : arr_rd;
`else
    logic unused_wr;
    assign unused_wr = ^{rst_n_i, we_i, a3_i, wd3_i};
    assign rd_o = arr_rd;
`endif
endmodule

// File: rtl/br_reg_bank.sv
// br_reg_bank: 32x32 RISC-V integer register file, two combinational reads, one sync write.
// Optional write-through forwarding is enabled by defining BR_BYPASS_EN.
module br_reg_bank
    import br_pkg::*;
#(
    parameter int DATA_W = BR_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  br_addr_t          a1,
    input  br_addr_t          a2,
    input  br_addr_t          a3,
    input  logic [DATA_W-1:0] wd3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] BankReg [0:NREGS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) BankReg[i] <= '0;
        end else if (we && a3 != ZERO_REG) begin
            BankReg[a3] <= wd3;
        end
    end

    br_read_port #(.DATA_W(DATA_W)) u_rp1 (
        .addr_i (a1),
        .regs_i (BankReg),
        .rst_n_i(rst_n),
        .we_i   (we),
        .a3_i   (a3),
        .wd3_i  (wd3),
        .rd_o   (rd1)
    );

    br_read_port #(.DATA_W(DATA_W)) u_rp2 (
        .addr_i (a2),
        .regs_i (BankReg),
        .rst_n_i(rst_n),
        .we_i   (we),
        .a3_i   (a3),
        .wd3_i  (wd3),
        .rd_o   (rd2)
    );
endmodule

// File: tb/tb_br_reg_bank.sv
// tb_br_reg_bank: randomized self-checking bench for br_reg_bank against an array model.
module tb_br_reg_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  a1 = '0, a2 = '0, a3 = '0;
    logic [31:0] wd3 = '0;
    logic [31:0] rd1, rd2;
    logic [31:0] model [32];
    int checks = 0;
    int failures = 0;

    br_reg_bank dut (
        .clk(clk), .rst_n(rst_n), .we(we), .a1(a1), .a2(a2), .a3(a3),
        .wd3(wd3), .rd1(rd1), .rd2(rd2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
`ifdef BR_BYPASS_EN
        if (rst_n && we && a3 != 0 && a == a3) return wd3;
`endif
        return (a == 0) ? 32'h0 : model[a];
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst_n && we && a3 != 0) model[a3] = wd3;
        @(negedge clk);
    endtask

    task automatic test_preload();
        we = 0; a1 = 3; a2 = 2;
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (rd1 !== 32'h01233333) begin failures++; $display("FAIL preload_rd1 cyc=%0d got=%h exp=%h", c, rd1, 32'h01233333); end
            checks++;
            if (rd2 !== 32'h01232222) begin failures++; $display("FAIL preload_rd2 cyc=%0d got=%h exp=%h", c, rd2, 32'h01232222); end
            step();
        end
    endtask

    task automatic test_write_x3();
        we = 1; a3 = 3; wd3 = 0; a1 = 3; a2 = 2;
        #1;
        checks++;
        if (rd1 !== exp_rd(3)) begin failures++; $display("FAIL pre_edge_x3 got=%h exp=%h", rd1, exp_rd(3)); end
        step();
        we = 0;
        #1;
        checks++;
        if (rd1 !== 32'h0) begin failures++; $display("FAIL post_edge_x3 got=%h exp=%h", rd1, 32'h0); end
        checks++;
        if (rd2 !== 32'h01232222) begin failures++; $display("FAIL post_edge_x2 got=%h exp=%h", rd2, 32'h01232222); end
    endtask

    task automatic test_x0();
        we = 1; a3 = 0; wd3 = 32'hDEADBEEF; a1 = 0; a2 = 0;
        #1;
        checks++;
        if (rd1 !== 32'h0) begin failures++; $display("FAIL x0_pre got=%h exp=0", rd1); end
        step();
        step();
        we = 0;
        #1;
        checks++;
        if (rd1 !== 32'h0) begin failures++; $display("FAIL x0_post_rd1 got=%h exp=0", rd1); end
        checks++;
        if (rd2 !== 32'h0) begin failures++; $display("FAIL x0_post_rd2 got=%h exp=0", rd2); end
    endtask

    task automatic test_bypass();
        we = 1; a3 = 7; wd3 = 32'h12345678; a1 = 7; a2 = 7;
        #1;
        checks++;
        if (rd1 !== exp_rd(7)) begin failures++; $display("FAIL fwd_x7_pre got=%h exp=%h", rd1, exp_rd(7)); end
        step();
        a3 = 0; a1 = 0; wd3 = 32'h87654321;
        #1;
        checks++;
        if (rd1 !== 32'h0) begin failures++; $display("FAIL fwd_x0_pre got=%h exp=0", rd1); end
        checks++;
        if (rd2 !== 32'h12345678) begin failures++; $display("FAIL fwd_x7_post got=%h exp=%h", rd2, 32'h12345678); end
        step();
        we = 0;
    endtask

    task automatic test_sweep();
        we = 1;
        for (int k = 1; k < 32; k++) begin
            a3 = 5'(k); wd3 = 32'(k) * 32'h01010101;
            step();
        end
        we = 0;
        for (int k = 0; k < 32; k++) begin
            a1 = 5'(k); a2 = 5'(31 - k);
            #1;
            checks++;
            if (rd1 !== 32'(k) * 32'h01010101) begin failures++; $display("FAIL sweep_rd1 x%0d got=%h exp=%h", k, rd1, 32'(k) * 32'h01010101); end
            checks++;
            if (rd2 !== 32'(31 - k) * 32'h01010101) begin failures++; $display("FAIL sweep_rd2 x%0d got=%h exp=%h", 31 - k, rd2, 32'(31 - k) * 32'h01010101); end
        end
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom); a1 = 5'($urandom); a2 = (n % 5 == 0) ? a1 : 5'($urandom);
            a3 = ((n % 3) == 0) ? a1 : 5'($urandom); wd3 = $urandom;
            #1;
            checks++;
            if (rd1 !== exp_rd(a1)) begin failures++; $display("FAIL rand_rd1 n=%0d a1=%0d got=%h exp=%h", n, a1, rd1, exp_rd(a1)); end
            checks++;
            if (rd2 !== exp_rd(a2)) begin failures++; $display("FAIL rand_rd2 n=%0d a2=%0d got=%h exp=%h", n, a2, rd2, exp_rd(a2)); end
            step();
        end
        we = 0;
    endtask

    task automatic test_reset();
        we = 1; a3 = 5; wd3 = 32'hA5A5A5A5; a1 = 5; a2 = 6;
        step();
        we = 0;
        #1;
        checks++;
        if (rd1 !== 32'hA5A5A5A5) begin failures++; $display("FAIL rst_pre_x5 got=%h exp=%h", rd1, 32'hA5A5A5A5); end
        #1 rst_n = 0;
        for (int i = 0; i < 32; i++) model[i] = 0;
        #1;
        checks++;
        if (rd1 !== 32'h0) begin failures++; $display("FAIL rst_async_x5 got=%h exp=0", rd1); end
        we = 1; a3 = 6; wd3 = 32'h5A5A5A5A; a1 = 6;
        #1;
        checks++;
        if (rd1 !== 32'h0) begin failures++; $display("FAIL rst_no_fwd got=%h exp=0", rd1); end
        step();
        we = 0;
        for (int k = 0; k < 32; k++) begin
            a1 = 5'(k);
            #1;
            checks++;
            if (rd1 !== 32'h0) begin failures++; $display("FAIL rst_clear x%0d got=%h exp=0", k, rd1); end
        end
        rst_n = 1;
        a1 = 6;
        #1;
        checks++;
        if (rd1 !== 32'h0) begin failures++; $display("FAIL rst_dropped_x6 got=%h exp=0", rd1); end
        step();
        we = 1; a3 = 6; wd3 = 32'hC0FFEE01;
        step();
        we = 0;
        #1;
        checks++;
        if (rd1 !== 32'hC0FFEE01) begin failures++; $display("FAIL rst_release_wr got=%h exp=%h", rd1, 32'hC0FFEE01); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 0;
        dut.BankReg[0] = 32'h01230000;
        dut.BankReg[1] = 32'h01231111;
        dut.BankReg[2] = 32'h01232222;
        dut.BankReg[3] = 32'h01233333;
        model[0] = 32'h01230000;
        model[1] = 32'h01231111;
        model[2] = 32'h01232222;
        model[3] = 32'h01233333;
        test_preload();
        test_write_x3();
        test_x0();
        test_bypass();
        test_sweep();
        test_random();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
